// File: rtl/follower_pkg.sv
// Shared types and constants for the line follower's IR/A2D sequencing.
//   state_t  : scheduler FSM states
//   pair_t   : emitter/sensor pair currently being measured
//   CH_*     : A2D channel numbers for each pair's right/left sensor
//   W_SH_*   : weight of each pair, expressed as a left-shift amount
//   ch_sel   : channel lookup for a pair and side
//   weigh    : zero-extended, weighted conversion result
//   sat12    : clamp a 16-bit signed sum to the 12-bit signed error range
package follower_pkg;

  typedef enum logic [2:0] {
    IDLE, SETTLE, CNV_R, WAIT_R, CNV_L, WAIT_L, NEXT, PUB
  } state_t;

  typedef enum logic [1:0] {
    PAIR_IN, PAIR_MID, PAIR_OUT
  } pair_t;

  localparam logic [2:0] CH_IN_R  = 3'd1;
  localparam logic [2:0] CH_IN_L  = 3'd0;
  localparam logic [2:0] CH_MID_R = 3'd4;
  localparam logic [2:0] CH_MID_L = 3'd2;
  localparam logic [2:0] CH_OUT_R = 3'd3;
  localparam logic [2:0] CH_OUT_L = 3'd7;

  localparam int W_SH_IN  = 0;
  localparam int W_SH_MID = 1;
  localparam int W_SH_OUT = 2;

  function automatic logic [2:0] ch_sel(input pair_t p, input logic left);
    case (p)
      PAIR_MID: return left ? CH_MID_L : CH_MID_R;
      PAIR_OUT: return left ? CH_OUT_L : CH_OUT_R;
      default:  return left ? CH_IN_L  : CH_IN_R;
    endcase
  endfunction

  function automatic logic [15:0] weigh(input pair_t p, input logic [11:0] r);
    case (p)
      PAIR_MID: return {4'b0, r} << W_SH_MID;
      PAIR_OUT: return {4'b0, r} << W_SH_OUT;
      default:  return {4'b0, r} << W_SH_IN;
    endcase
  endfunction

  function automatic logic signed [11:0] sat12(input logic signed [15:0] a);
    if (a > 16'sd2047)
      return 12'h7FF;
    else if (a < -16'sd2048)
      return 12'h800;
    else
      return a[11:0];
  endfunction

endpackage

// File: rtl/ir_settle_tmr.sv
// Loadable down-counter with a terminal-count flag. Serves both as the
// emitter settle timer and as the conversion watchdog.
//   clk, rst_n : clock, async active-low reset
//   load       : load load_val this cycle (takes priority over en)
//   en         : decrement while nonzero
//   load_val   : value loaded; done asserts after load_val decrements
//   done       : count is zero
module ir_settle_tmr #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (en && (cnt != '0))
      cnt <= cnt - 1'b1;
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/ir_a2d_sched.sv
// IR emitter / A2D conversion scheduler. For each sensor pair (inner, middle,
// outer) it lights the pair's emitter, lets it settle, converts right then
// left, and accumulates weighted (right - left). After the outer pair the
// saturated 12-bit signed sum is published as the steering error.
//   clk, rst_n         : clock, async active-low reset
//   go                 : sweeps run while high
//   strt_cnv, chnnl    : conversion request and channel to the A2D
//   cnv_cmplt, res     : conversion done pulse and result from the A2D
//   IR_in/mid/out_en   : emitter enables, at most one high
//   error, err_vld     : steering error and its update pulse
//   tmo                : sticky conversion timeout
//
// state  | meaning
// IDLE   | waiting for go, emitters off
// SETTLE | pair emitter on, waiting SETTLE_CYC cycles
// CNV_R  | strt_cnv pulse for right channel
// WAIT_R | waiting on right result (watchdog running)
// CNV_L  | strt_cnv pulse for left channel
// WAIT_L | waiting on left result (watchdog running)
// NEXT   | emitters off one cycle, pick next pair or publish
// PUB    | err_vld high with new error
module ir_a2d_sched
  import follower_pkg::*;
#(
  parameter int SETTLE_CYC = 4096,
  parameter int CNV_TMO    = 65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        go,
  output logic        strt_cnv,
  output logic [2:0]  chnnl,
  input  logic        cnv_cmplt,
  input  logic [11:0] res,
  output logic        IR_in_en,
  output logic        IR_mid_en,
  output logic        IR_out_en,
  output logic [11:0] error,
  output logic        err_vld,
  output logic        tmo
);

  localparam logic [15:0] SETTLE_LD = 16'(SETTLE_CYC - 1);
  localparam logic [15:0] TMO_LD    = 16'(CNV_TMO - 1);

  state_t             state, nxt;
  pair_t              pair, pair_nxt;
  logic signed [15:0] acc;
  logic               acc_clr, acc_add, acc_sub;
  logic               abort, abort_set, abort_clr;
  logic               tmr_load, tmr_en, tmr_done;
  logic [15:0]        tmr_val;
  logic               pub_now, tmo_set;
  logic               emit_on;

  ir_settle_tmr #(.W(16)) u_tmr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .en       (tmr_en),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pair    <= PAIR_IN;
      acc     <= '0;
      abort   <= 1'b0;
      tmo     <= 1'b0;
      error   <= '0;
      err_vld <= 1'b0;
    end else begin
      state   <= nxt;
      pair    <= pair_nxt;
      err_vld <= pub_now;
      if (pub_now)
        error <= sat12(acc);
      if (tmo_set)
        tmo <= 1'b1;
      if (abort_clr)
        abort <= 1'b0;
      else if (abort_set)
        abort <= 1'b1;
      if (acc_clr)
        acc <= '0;
      else if (acc_add)
        acc <= acc + $signed(weigh(pair, res));
      else if (acc_sub)
        acc <= acc - $signed(weigh(pair, res));
    end
  end

  always_comb begin
    nxt       = state;
    pair_nxt  = pair;
    acc_clr   = 1'b0;
    acc_add   = 1'b0;
    acc_sub   = 1'b0;
    abort_set = 1'b0;
    abort_clr = 1'b0;
    tmr_load  = 1'b0;
    tmr_en    = 1'b0;
    tmr_val   = SETTLE_LD;
    pub_now   = 1'b0;
    tmo_set   = 1'b0;
    case (state)
      IDLE: begin
        abort_clr = 1'b1;
        if (go) begin
          acc_clr  = 1'b1;
          pair_nxt = PAIR_IN;
          tmr_load = 1'b1;
          nxt      = SETTLE;
        end
      end
      SETTLE: begin
        if (!go)
          nxt = IDLE;
        else if (tmr_done)
          nxt = CNV_R;
        else
          tmr_en = 1'b1;
      end
      CNV_R, CNV_L: begin
        // A started conversion always runs to completion, so a go drop here
        // is remembered and resolved when the result arrives.
        abort_set = !go;
        tmr_load  = 1'b1;
        tmr_val   = TMO_LD;
        nxt       = (state == CNV_R) ? WAIT_R : WAIT_L;
      end
      WAIT_R, WAIT_L: begin
        abort_set = !go;
        if (cnv_cmplt) begin
          if (abort || !go)
            nxt = IDLE;
          else if (state == WAIT_R) begin
            acc_add = 1'b1;
            nxt     = CNV_L;
          end else begin
            acc_sub = 1'b1;
            nxt     = NEXT;
          end
        end else if (tmr_done) begin
          tmo_set = 1'b1;
          nxt     = IDLE;
        end else
          tmr_en = 1'b1;
      end
      NEXT: begin
        if (!go)
          nxt = IDLE;
        else if (pair == PAIR_OUT) begin
          pub_now = 1'b1;
          nxt     = PUB;
        end else begin
          pair_nxt = (pair == PAIR_IN) ? PAIR_MID : PAIR_OUT;
          tmr_load = 1'b1;
          nxt      = SETTLE;
        end
      end
      PUB: begin
        if (go) begin
          acc_clr  = 1'b1;
          pair_nxt = PAIR_IN;
          tmr_load = 1'b1;
          nxt      = SETTLE;
        end else
          nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  assign emit_on  = (state == SETTLE) || (state == CNV_R) || (state == WAIT_R) ||
                    (state == CNV_L)  || (state == WAIT_L);
  assign IR_in_en  = emit_on && (pair == PAIR_IN);
  assign IR_mid_en = emit_on && (pair == PAIR_MID);
  assign IR_out_en = emit_on && (pair == PAIR_OUT);
  assign strt_cnv  = (state == CNV_R) || (state == CNV_L);

  always_comb begin
    chnnl = '0;
    case (state)
      CNV_R, WAIT_R: chnnl = ch_sel(pair, 1'b0);
      CNV_L, WAIT_L: chnnl = ch_sel(pair, 1'b1);
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ir_a2d_sched.sv
module tb_ir_a2d_sched;

  localparam int SETTLE_CYC = 8;
  localparam int CNV_TMO    = 100;

  logic        clk = 1'b0;
  logic        rst_n, go, cnv_cmplt;
  logic [11:0] res;
  logic        strt_cnv, IR_in_en, IR_mid_en, IR_out_en, err_vld, tmo;
  logic [2:0]  chnnl;
  logic [11:0] error;

  int total = 0;
  int bad   = 0;

  // A2D model state
  logic [11:0] ch_val [8];
  bit          busy = 0, withhold = 0, spur_en = 0;
  int          lat = 0, lat_sum = 0, hold_err = 0;
  logic [2:0]  req_ch;

  // monitor state
  logic [2:0]  chq [$];
  logic [2:0]  emq [$];
  logic [2:0]  em, prev_em = '0;
  int          multi_hi = 0, vld_cnt = 0;
  logic [11:0] last_exp = '0;

  ir_a2d_sched #(.SETTLE_CYC(SETTLE_CYC), .CNV_TMO(CNV_TMO)) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .strt_cnv(strt_cnv), .chnnl(chnnl),
    .cnv_cmplt(cnv_cmplt), .res(res), .IR_in_en(IR_in_en), .IR_mid_en(IR_mid_en),
    .IR_out_en(IR_out_en), .error(error), .err_vld(err_vld), .tmo(tmo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Steering error straight from the weighting rule: sum of w*(R-L), clamped.
  function automatic logic [11:0] ref_err();
    int s;
    s = (int'(ch_val[1]) - int'(ch_val[0]))
      + 2 * (int'(ch_val[4]) - int'(ch_val[2]))
      + 4 * (int'(ch_val[3]) - int'(ch_val[7]));
    if (s > 2047)  s = 2047;
    if (s < -2048) s = -2048;
    return 12'(s);
  endfunction

  function automatic logic [31:0] pack3(input logic [2:0] q[$]);
    logic [31:0] p;
    p = 32'(q.size()) << 24;
    foreach (q[i]) if (i < 8) p[i*3 +: 3] = q[i];
    return p;
  endfunction

  // A2D interface model: answers each request after 0..5 extra cycles,
  // optionally ignores requests, optionally emits stray completion pulses.
  always @(negedge clk) begin
    cnv_cmplt = 1'b0;
    if (!rst_n) busy = 0;
    else if (busy) begin
      if (lat == 0) begin
        cnv_cmplt = 1'b1;
        res = ch_val[req_ch];
        busy = 0;
        if (chnnl !== req_ch) hold_err++;
      end else lat--;
    end else if (strt_cnv) begin
      if (!withhold) begin
        busy = 1;
        req_ch = chnnl;
        lat = $urandom_range(0, 5);
        lat_sum += lat;
      end
    end else if (spur_en && ($urandom_range(0, 7) == 0)) begin
      cnv_cmplt = 1'b1;
      res = 12'($urandom);
    end
  end

  always @(negedge clk) begin
    em = {IR_out_en, IR_mid_en, IR_in_en};
    if ($countones(em) > 1) multi_hi++;
    if (em != 3'b000 && em != prev_em) emq.push_back(em);
    prev_em = em;
    if (strt_cnv) chq.push_back(chnnl);
    if (err_vld) vld_cnt++;
  end

  task automatic wait_vld(input int bound, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!err_vld && cyc < bound);
    if (!err_vld) chk("vld_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_sweep(input string tag, input bit chk_lat);
    logic [11:0] exp;
    logic [2:0]  exp_ch [$];
    logic [2:0]  exp_em [$];
    int          cyc;
    exp_ch = '{3'd1, 3'd0, 3'd4, 3'd2, 3'd3, 3'd7};
    exp_em = '{3'b001, 3'b010, 3'b100};
    exp = ref_err();
    chq.delete();
    emq.delete();
    lat_sum = 0;
    wait_vld(1000, cyc);
    chk({tag, "_err"}, 32'(error), 32'(exp));
    chk({tag, "_chan"}, pack3(chq), pack3(exp_ch));
    chk({tag, "_emit"}, pack3(emq), pack3(exp_em));
    chk({tag, "_onehot"}, multi_hi, 0);
    chk({tag, "_hold"}, hold_err, 0);
    if (chk_lat) chk({tag, "_lat"}, cyc, 3 * (SETTLE_CYC + 1) + 12 + lat_sum + 1);
    last_exp = exp;
  endtask

  task automatic set_all(input logic [11:0] r, input logic [11:0] l);
    ch_val[1] = r; ch_val[4] = r; ch_val[3] = r;
    ch_val[0] = l; ch_val[2] = l; ch_val[7] = l;
    ch_val[5] = 12'h0; ch_val[6] = 12'h0;
  endtask

  initial begin
    int n, v0;
    rst_n = 1'b0;
    go    = 1'b0;
    set_all(12'h800, 12'h800);
    repeat (3) @(negedge clk);
    chk("rst_emit", {IR_out_en, IR_mid_en, IR_in_en}, 0);
    chk("rst_cnv", {strt_cnv, chnnl}, 0);
    chk("rst_out", {err_vld, tmo, error}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    go = 1'b1;
    do_sweep("mid_scale", 1);
    set_all(12'h100, 12'h000);
    do_sweep("r100", 0);
    set_all(12'hFFF, 12'h000);
    do_sweep("sat_pos", 0);
    set_all(12'h000, 12'hFFF);
    do_sweep("sat_neg", 0);

    spur_en = 1;
    for (int s = 0; s < 6; s++) begin
      foreach (ch_val[i]) ch_val[i] = 12'($urandom_range(0, 4095));
      do_sweep("rand", 0);
    end
    spur_en = 0;

    // drop go while waiting for the middle pair's left conversion
    foreach (ch_val[i]) ch_val[i] = 12'($urandom_range(0, 4095));
    chq.delete();
    n = 0;
    do begin @(negedge clk); n++; end while (!(strt_cnv && chnnl == 3'd2) && n < 300);
    chk("abort_reach", {strt_cnv, chnnl}, {1'b1, 3'd2});
    @(negedge clk);
    go = 1'b0;
    v0 = vld_cnt;
    repeat (20) @(negedge clk);
    chk("abort_vld", vld_cnt, v0);
    chk("abort_err", 32'(error), 32'(last_exp));
    chk("abort_emit", {IR_out_en, IR_mid_en, IR_in_en}, 0);
    chk("abort_a2d_done", busy, 0);
    chk("abort_no_cnv", chq.size(), 4);

    // conversion watchdog
    withhold = 1;
    go = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!strt_cnv && n < 300);
    chk("tmo_reach", strt_cnv, 1);
    repeat (CNV_TMO) @(negedge clk);
    chk("tmo_early", tmo, 0);
    @(negedge clk);
    chk("tmo_set", tmo, 1);
    chk("tmo_emit", {IR_out_en, IR_mid_en, IR_in_en}, 0);
    chk("tmo_vld", err_vld, 0);
    withhold = 0;
    foreach (ch_val[i]) ch_val[i] = 12'($urandom_range(0, 4095));
    do_sweep("after_tmo", 0);
    chk("tmo_sticky", tmo, 1);

    // asynchronous reset while the outer pair settles
    n = 0;
    do begin @(negedge clk); n++; end while (!IR_out_en && n < 300);
    chk("out_reach", IR_out_en, 1);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_emit", {IR_out_en, IR_mid_en, IR_in_en}, 0);
    chk("arst_tmo", tmo, 0);
    chk("arst_err", 32'(error), 0);
    chk("arst_misc", {strt_cnv, chnnl, err_vld}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    foreach (ch_val[i]) ch_val[i] = 12'($urandom_range(0, 4095));
    do_sweep("post_rst", 1);

    go = 1'b0;
    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
